// File: rtl/mio_bus_arbiter.sv
// Arbitrates the shared memory/IO bus between the CPU controller and a DMA master.
// CPU has priority, a streak counter guarantees DMA progress, and a timeout aborts hung transfers.
module mio_bus_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_CPU_BURST = 4,
    parameter int TIMEOUT       = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              owner,
    output logic              bus_err
);

    localparam int STREAK_W = $clog2(MAX_CPU_BURST + 1);
    localparam int TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_BURST);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]    TMO_ONE    = TMO_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    state_t              state_r,     state_s;
    logic [STREAK_W-1:0] streak_r,    streak_s;
    logic [TMO_W-1:0]    tmo_r,       tmo_s;
    logic                mem_req_r,   mem_req_s;
    logic                mem_we_r,    mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_r,  mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic                owner_r,     owner_s;
    logic                bus_err_r,   bus_err_s;
    logic [DATA_W-1:0]   cpu_rdata_r, cpu_rdata_s;
    logic [DATA_W-1:0]   dma_rdata_r, dma_rdata_s;
    logic                cpu_ready_r, cpu_ready_s;
    logic                dma_ready_r, dma_ready_s;
    logic                cpu_eff_s,   dma_eff_s;

    // Next-state, arbitration and completion logic.
    always_comb begin
        state_s     = state_r;
        streak_s    = streak_r;
        tmo_s       = tmo_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        owner_s     = owner_r;
        bus_err_s   = bus_err_r;
        cpu_rdata_s = cpu_rdata_r;
        dma_rdata_s = dma_rdata_r;
        cpu_ready_s = 1'b0;
        dma_ready_s = 1'b0;
        // A master that sees its ready this cycle must not be granted again.
        cpu_eff_s   = cpu_req & ~cpu_ready_r;
        dma_eff_s   = dma_req & ~dma_ready_r;

        case (state_r)
            ST_IDLE: begin
                if (cpu_eff_s && (!dma_eff_s || (streak_r < STREAK_MAX))) begin
                    state_s     = ST_XFER;
                    mem_req_s   = 1'b1;
                    tmo_s       = '0;
                    owner_s     = 1'b0;
                    mem_we_s    = cpu_we;
                    mem_addr_s  = cpu_addr;
                    mem_wdata_s = cpu_wdata;
                    if (!dma_eff_s) begin
                        streak_s = '0;
                    end else if (streak_r < STREAK_MAX) begin
                        streak_s = streak_r + STREAK_ONE;
                    end else begin
                        streak_s = STREAK_MAX;
                    end
                end else if (dma_eff_s) begin
                    state_s     = ST_XFER;
                    mem_req_s   = 1'b1;
                    tmo_s       = '0;
                    owner_s     = 1'b1;
                    mem_we_s    = dma_we;
                    mem_addr_s  = dma_addr;
                    mem_wdata_s = dma_wdata;
                    streak_s    = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                // An ack arriving on the timeout cycle still completes normally.
                if (mem_ack) begin
                    state_s   = ST_DONE;
                    mem_req_s = 1'b0;
                    if (owner_r) begin
                        dma_ready_s = 1'b1;
                        if (!mem_we_r) begin
                            dma_rdata_s = mem_rdata;
                        end else begin
                            dma_rdata_s = dma_rdata_r;
                        end
                    end else begin
                        cpu_ready_s = 1'b1;
                        if (!mem_we_r) begin
                            cpu_rdata_s = mem_rdata;
                        end else begin
                            cpu_rdata_s = cpu_rdata_r;
                        end
                    end
                end else if (tmo_r == TMO_LAST) begin
                    state_s   = ST_ABORT;
                    mem_req_s = 1'b0;
                    bus_err_s = 1'b1;
                    if (owner_r) begin
                        dma_ready_s = 1'b1;
                        dma_rdata_s = '0;
                    end else begin
                        cpu_ready_s = 1'b1;
                        cpu_rdata_s = '0;
                    end
                end else begin
                    tmo_s = tmo_r + TMO_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            ST_ABORT: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            streak_r    <= '0;
            tmo_r       <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            owner_r     <= 1'b0;
            bus_err_r   <= 1'b0;
            cpu_rdata_r <= '0;
            dma_rdata_r <= '0;
            cpu_ready_r <= 1'b0;
            dma_ready_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            streak_r    <= streak_s;
            tmo_r       <= tmo_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            owner_r     <= owner_s;
            bus_err_r   <= bus_err_s;
            cpu_rdata_r <= cpu_rdata_s;
            dma_rdata_r <= dma_rdata_s;
            cpu_ready_r <= cpu_ready_s;
            dma_ready_r <= dma_ready_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign owner     = owner_r;
    assign bus_err   = bus_err_r;
    assign cpu_rdata = cpu_rdata_r;
    assign dma_rdata = dma_rdata_r;
    assign cpu_ready = cpu_ready_r;
    assign dma_ready = dma_ready_r;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Bench for mio_bus_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level reference model of the arbitration rules.
module tb_mio_bus_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;
    localparam int TMO  = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dma_req, dma_we, mem_ack;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, mem_rdata;
    logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          cpu_ready, dma_ready, mem_req, mem_we, owner, bus_err;

    mio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_CPU_BURST(MAXB), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .owner(owner), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one transaction in flight at most, tracked by its age.
    bit          m_active;
    int          m_age;
    int          m_streak;
    logic        m_we, m_mem_req, m_owner, m_bus_err, m_cpu_ready, m_dma_ready;
    logic [31:0] m_addr, m_wdata, m_cpu_rdata, m_dma_rdata;

    // Stimulus knobs and bookkeeping.
    int          p_cpu, p_dma, p_ack, p_spur, ack_at, mreq_cnt;
    bit          cpu_pend, dma_pend;
    logic [31:0] last_ack_data;
    bit          owner_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_grant(input bit who, input bit we, input logic [31:0] a, input logic [31:0] d);
        m_active  = 1'b1;
        m_age     = 0;
        m_mem_req = 1'b1;
        m_owner   = who;
        m_we      = we;
        m_addr    = a;
        m_wdata   = d;
    endtask

    task automatic model_step();
        bit showing_ready;
        showing_ready = m_cpu_ready | m_dma_ready;
        m_cpu_ready = 1'b0;
        m_dma_ready = 1'b0;
        if (reset) begin
            m_active = 1'b0; m_age = 0; m_streak = 0; m_we = 1'b0; m_mem_req = 1'b0;
            m_owner = 1'b0; m_bus_err = 1'b0; m_addr = '0; m_wdata = '0;
            m_cpu_rdata = '0; m_dma_rdata = '0;
        end else if (m_active) begin
            if (mem_ack || m_age == TMO - 1) begin
                m_active  = 1'b0;
                m_mem_req = 1'b0;
                if (m_owner) m_dma_ready = 1'b1; else m_cpu_ready = 1'b1;
                if (!mem_ack) begin
                    m_bus_err = 1'b1;
                    if (m_owner) m_dma_rdata = '0; else m_cpu_rdata = '0;
                end else if (!m_we) begin
                    if (m_owner) m_dma_rdata = mem_rdata; else m_cpu_rdata = mem_rdata;
                end
            end else begin
                m_age++;
            end
        end else if (!showing_ready) begin
            if (cpu_req && (!dma_req || m_streak < MAXB)) begin
                model_grant(1'b0, cpu_we, cpu_addr, cpu_wdata);
                m_streak = dma_req ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 0;
            end else if (dma_req) begin
                model_grant(1'b1, dma_we, dma_addr, dma_wdata);
                m_streak = 0;
            end
        end
    endtask

    task automatic compare();
        check_eq("mem_req",   32'(mem_req),   32'(m_mem_req));
        check_eq("owner",     32'(owner),     32'(m_owner));
        check_eq("bus_err",   32'(bus_err),   32'(m_bus_err));
        check_eq("cpu_ready", 32'(cpu_ready), 32'(m_cpu_ready));
        check_eq("dma_ready", 32'(dma_ready), 32'(m_dma_ready));
        check_eq("cpu_rdata", cpu_rdata, m_cpu_rdata);
        check_eq("dma_rdata", dma_rdata, m_dma_rdata);
        if (m_mem_req) begin
            check_eq("mem_we",    32'(mem_we), 32'(m_we));
            check_eq("mem_addr",  mem_addr,  m_addr);
            check_eq("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    // Memory responder: ack_at>0 acks on that cycle of mem_req, 0 acks randomly, <0 never.
    task automatic drive_mem();
        if (mem_req) mreq_cnt++; else mreq_cnt = 0;
        if (mem_req && mreq_cnt == 1) owner_q.push_back(owner);
        mem_rdata = $urandom;
        if (mem_req) begin
            if (ack_at > 0)       mem_ack = (mreq_cnt == ack_at);
            else if (ack_at == 0) mem_ack = ($urandom_range(99) < p_ack);
            else                  mem_ack = 1'b0;
        end else begin
            mem_ack = ($urandom_range(99) < p_spur);
        end
        if (mem_ack) last_ack_data = mem_rdata;
    endtask

    task automatic drive_masters();
        if (cpu_ready) cpu_pend = 1'b0;
        else if (!cpu_pend) begin
            if ($urandom_range(99) < p_cpu) begin
                cpu_pend = 1'b1; cpu_req = 1'b1; cpu_we = 1'($urandom);
                cpu_addr = $urandom; cpu_wdata = $urandom;
            end else cpu_req = 1'b0;
        end
        if (dma_ready) dma_pend = 1'b0;
        else if (!dma_pend) begin
            if ($urandom_range(99) < p_dma) begin
                dma_pend = 1'b1; dma_req = 1'b1; dma_we = 1'($urandom);
                dma_addr = $urandom; dma_wdata = $urandom;
            end else dma_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; mem_ack = 1'b0;
        cpu_pend = 1'b0; dma_pend = 1'b0; p_spur = 0; ack_at = 2;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic cpu_txn(input bit we, input logic [31:0] a, input logic [31:0] d, input int ack,
                           output int xfer, output bit seen, output logic [31:0] rd, output logic err);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; ack_at = ack;
        xfer = 0; seen = 1'b0; rd = '0; err = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            drive_mem();
            tick();
            if (mem_req) xfer++;
            if (cpu_ready) begin seen = 1'b1; rd = cpu_rdata; err = bus_err; end
        end
        cpu_req = 1'b0;
        drive_mem();
        tick();
    endtask

    initial begin
        int          xfer;
        bit          seen, hit;
        logic [31:0] rd;
        logic        err;
        bit          exp_seq [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0; mreq_cnt = 0; last_ack_data = '0;
        p_cpu = 0; p_dma = 0; p_ack = 50; p_spur = 0; ack_at = 2;

        do_reset();
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_owner",   32'(owner),   32'd0);
        check_eq("rst_bus_err", 32'(bus_err), 32'd0);
        check_eq("rst_rdata",   cpu_rdata | dma_rdata, 32'd0);

        // Scenario 1: single CPU read, ack in the second mem_req cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0; ack_at = 2;
        drive_mem(); tick();
        check_eq("t1_mreq_c1", 32'(mem_req), 32'd1);
        check_eq("t1_addr", mem_addr, 32'h10);
        drive_mem(); tick();
        check_eq("t1_mreq_c2", 32'(mem_req), 32'd1);
        drive_mem(); mem_rdata = 32'hCAFE0001; tick();
        check_eq("t1_ready_c3", 32'(cpu_ready), 32'd1);
        check_eq("t1_rdata", cpu_rdata, 32'hCAFE0001);
        check_eq("t1_mreq_c3", 32'(mem_req), 32'd0);
        drive_mem(); tick();
        check_eq("t1_masked", 32'(mem_req), 32'd0);
        cpu_req = 1'b0; drive_mem(); tick();

        // Scenario 2: both masters held high, starvation guard.
        do_reset();
        owner_q.delete();
        p_cpu = 100; p_dma = 100; ack_at = 2;
        for (int i = 0; i < 200 && owner_q.size() < 10; i++) begin
            drive_masters(); drive_mem(); tick();
        end
        check_eq("t2_grants", 32'(owner_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < owner_q.size(); i++) check_eq("t2_owner", 32'(owner_q[i]), 32'(exp_seq[i]));
        p_cpu = 0; p_dma = 0;
        for (int i = 0; i < 30; i++) begin drive_masters(); drive_mem(); tick(); end

        // Scenario 3: a read to load rdata, then a write that times out.
        do_reset();
        cpu_txn(1'b0, 32'h20, 32'h0, 2, xfer, seen, rd, err);
        check_eq("t3_read_seen", 32'(seen), 32'd1);
        check_eq("t3_read_data", rd, last_ack_data);
        cpu_txn(1'b1, 32'h24, 32'h5555AAAA, -1, xfer, seen, rd, err);
        check_eq("t3_abort_seen", 32'(seen), 32'd1);
        check_eq("t3_xfer_cycles", 32'(xfer), 32'd15);
        check_eq("t3_abort_rdata", rd, 32'd0);
        check_eq("t3_bus_err", 32'(bus_err), 32'd1);
        for (int i = 0; i < 8; i++) begin drive_mem(); tick(); end
        check_eq("t3_bus_err_sticky", 32'(bus_err), 32'd1);
        do_reset();
        check_eq("t3_bus_err_cleared", 32'(bus_err), 32'd0);

        // Scenario 4: ack on the final allowed cycle wins over the timeout.
        cpu_txn(1'b0, 32'h30, 32'h0, 15, xfer, seen, rd, err);
        check_eq("t4_seen", 32'(seen), 32'd1);
        check_eq("t4_xfer_cycles", 32'(xfer), 32'd15);
        check_eq("t4_rdata", rd, last_ack_data);
        check_eq("t4_no_err", 32'(err), 32'd0);

        // Scenario 5: reset in the second transfer cycle of a DMA access.
        do_reset();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40; dma_wdata = '0; ack_at = -1;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            drive_mem();
            if (mreq_cnt == 2) begin
                hit = 1'b1;
                check_eq("t5_owner_dma", 32'(owner), 32'd1);
                reset = 1'b1; dma_req = 1'b0; mem_ack = 1'b0;
            end
            tick();
        end
        reset = 1'b0;
        check_eq("t5_hit", 32'(hit), 32'd1);
        check_eq("t5_mem_req", 32'(mem_req), 32'd0);
        check_eq("t5_owner", 32'(owner), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive_mem(); tick();
            check_eq("t5_no_ready", 32'(dma_ready | cpu_ready), 32'd0);
        end
        dma_req = 1'b1; dma_addr = 32'h44; ack_at = 2; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            drive_mem(); tick();
            if (dma_ready) begin
                seen = 1'b1;
                check_eq("t5_regrant_data", dma_rdata, last_ack_data);
            end
        end
        check_eq("t5_regrant_seen", 32'(seen), 32'd1);
        dma_req = 1'b0; drive_mem(); tick();

        // Random traffic with varying load, ack rate and stray acks.
        do_reset();
        p_spur = 10; ack_at = 0;
        for (int seg = 0; seg < 6; seg++) begin
            p_cpu = $urandom_range(100);
            p_dma = $urandom_range(100);
            p_ack = (seg == 2) ? 8 : $urandom_range(20, 100);
            for (int i = 0; i < 400; i++) begin drive_masters(); drive_mem(); tick(); end
        end
        p_cpu = 0; p_dma = 0; p_ack = 100;
        for (int i = 0; i < 60; i++) begin drive_masters(); drive_mem(); tick(); end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
